// File: rtl/hysteresis_threshold.sv
// Double-threshold classification followed by 8-neighbour hysteresis over a 3x3
// class window; emits a binary edge map in raster order.
module hysteresis_threshold #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] hi_thr,
  input  logic [DATA_W-1:0] lo_thr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              frame_done,
  output logic              overrun
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(TOTAL + IMG_W + 1);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  localparam logic [IDX_W-1:0] IDX_FILL_END = IDX_W'(IMG_W);
  localparam logic [IDX_W-1:0] IDX_EMIT     = IDX_W'(IMG_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST_IN  = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_FL  = IDX_W'(TOTAL + IMG_W);
  localparam logic [CW-1:0]    COL_LAST     = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST     = RW'(IMG_H - 1);

  localparam logic [1:0] CLS_NONE   = 2'd0;
  localparam logic [1:0] CLS_WEAK   = 2'd1;
  localparam logic [1:0] CLS_STRONG = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH} state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] hi_l_reg, lo_l_reg;
  logic [IDX_W-1:0]  in_idx_reg;
  logic [CW-1:0]     in_col_reg;
  logic              overrun_reg;

  logic              flush_slot, take_pix, slot;
  logic [DATA_W-1:0] thr_hi, thr_lo;
  logic [1:0]        slot_cls;

  logic              a_valid_reg, a_emit_reg;
  logic [1:0]        a_cls_reg;
  logic [CW-1:0]     a_col_reg;

  logic [1:0]        lb0_mem [IMG_W];
  logic [1:0]        lb1_mem [IMG_W];
  logic [1:0]        lb0_q_reg, lb1_q_reg;

  logic              b_valid_reg;
  logic [1:0]        win_reg [3][3];

  logic [CW-1:0]     out_col_reg;
  logic [RW-1:0]     out_row_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_out_valid_reg, frame_done_reg;

  logic              top_ok, bot_ok, left_ok, right_ok, hit;
  logic [8:0]        nb_strong;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (data_in_valid) state_next = ST_FILL;
      ST_FILL:  if (data_in_valid && in_idx_reg == IDX_FILL_END) state_next = ST_RUN;
      ST_RUN:   if (data_in_valid && in_idx_reg == IDX_LAST_IN) state_next = ST_FLUSH;
      ST_FLUSH: if (in_idx_reg == IDX_LAST_FL) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The first pixel of a frame is classified against the live thresholds,
  // since the latched copies are only written on that same edge.
  always_comb begin
    flush_slot = (state_reg == ST_FLUSH);
    take_pix   = data_in_valid && !flush_slot;
    slot       = take_pix || flush_slot;
    thr_hi     = (state_reg == ST_IDLE) ? hi_thr : hi_l_reg;
    thr_lo     = (state_reg == ST_IDLE) ? lo_thr : lo_l_reg;
  end

  always_comb begin
    slot_cls = CLS_NONE;
    if (!flush_slot) begin
      if (data_in > thr_hi)       slot_cls = CLS_STRONG;
      else if (data_in >= thr_lo) slot_cls = CLS_WEAK;
    end
  end

  // ---------------- stage A: classify ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_l_reg    <= '0;
      lo_l_reg    <= '0;
      in_idx_reg  <= '0;
      in_col_reg  <= '0;
      overrun_reg <= 1'b0;
      a_valid_reg <= 1'b0;
      a_emit_reg  <= 1'b0;
      a_cls_reg   <= CLS_NONE;
      a_col_reg   <= '0;
    end else begin
      a_valid_reg <= slot;
      if (slot) begin
        a_cls_reg  <= slot_cls;
        a_col_reg  <= in_col_reg;
        a_emit_reg <= (in_idx_reg >= IDX_EMIT);
        if (flush_slot && in_idx_reg == IDX_LAST_FL) begin
          in_idx_reg <= '0;
          in_col_reg <= '0;
        end else begin
          in_idx_reg <= in_idx_reg + 1'b1;
          in_col_reg <= (in_col_reg == COL_LAST) ? '0 : in_col_reg + 1'b1;
        end
      end
      if (state_reg == ST_IDLE && data_in_valid) begin
        hi_l_reg <= hi_thr;
        lo_l_reg <= lo_thr;
      end
      if (flush_slot && data_in_valid) overrun_reg <= 1'b1;
    end
  end

  // Class line buffers: read issued with the slot, written one cycle later.
  always_ff @(posedge clk) begin
    if (slot) begin
      lb0_q_reg <= lb0_mem[in_col_reg];
      lb1_q_reg <= lb1_mem[in_col_reg];
    end
    if (a_valid_reg) begin
      lb0_mem[a_col_reg] <= a_cls_reg;
      lb1_mem[a_col_reg] <= lb0_q_reg;
    end
  end

  // ---------------- stage B: 3x3 window ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_valid_reg <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_reg[r][c] <= CLS_NONE;
    end else begin
      b_valid_reg <= a_valid_reg && a_emit_reg;
      if (a_valid_reg) begin
        for (int r = 0; r < 3; r++) begin
          win_reg[r][0] <= win_reg[r][1];
          win_reg[r][1] <= win_reg[r][2];
        end
        win_reg[0][2] <= lb1_q_reg;
        win_reg[1][2] <= lb0_q_reg;
        win_reg[2][2] <= a_cls_reg;
      end
    end
  end

  // ---------------- stage C: decision ----------------
  // Border masks stop stale line-buffer rows and the line wrap from leaking in.
  assign top_ok   = (out_row_reg != '0);
  assign bot_ok   = (out_row_reg != ROW_LAST);
  assign left_ok  = (out_col_reg != '0);
  assign right_ok = (out_col_reg != COL_LAST);

  for (genvar gi = 0; gi < 9; gi++) begin : g_nb
    localparam int R = gi / 3;
    localparam int C = gi % 3;
    logic row_ok, col_ok;
    if (R == 0)      assign row_ok = top_ok;
    else if (R == 2) assign row_ok = bot_ok;
    else             assign row_ok = 1'b1;
    if (C == 0)      assign col_ok = left_ok;
    else if (C == 2) assign col_ok = right_ok;
    else             assign col_ok = 1'b1;
    if (gi == 4) assign nb_strong[gi] = 1'b0;
    else         assign nb_strong[gi] = row_ok && col_ok && (win_reg[R][C] == CLS_STRONG);
  end

  assign hit = (win_reg[1][1] == CLS_STRONG) || ((win_reg[1][1] == CLS_WEAK) && (|nb_strong));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_reg       <= '0;
      data_out_valid_reg <= 1'b0;
      frame_done_reg     <= 1'b0;
      out_col_reg        <= '0;
      out_row_reg        <= '0;
    end else begin
      data_out_valid_reg <= b_valid_reg;
      frame_done_reg     <= 1'b0;
      if (b_valid_reg) begin
        data_out_reg <= hit ? '1 : '0;
        if (out_col_reg == COL_LAST) begin
          out_col_reg <= '0;
          if (out_row_reg == ROW_LAST) begin
            out_row_reg    <= '0;
            frame_done_reg <= 1'b1;
          end else begin
            out_row_reg <= out_row_reg + 1'b1;
          end
        end else begin
          out_col_reg <= out_col_reg + 1'b1;
        end
      end
    end
  end

  assign data_out       = data_out_reg;
  assign data_out_valid = data_out_valid_reg;
  assign frame_done     = frame_done_reg;
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_hysteresis_threshold.sv
// Directed frames on a 4x4 image with hand-computed edge maps, latency and
// robustness checks for hysteresis_threshold.
module tb_hysteresis_threshold;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] hi_thr, lo_thr, data_in;
  logic       data_in_valid;
  logic [7:0] data_out;
  logic       data_out_valid, frame_done, overrun;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [7:0] outs[$];
  int         out_cyc[$];
  int         fd_cnt, fd_idx;
  int         in_cyc[N];
  logic [7:0] pix[N];

  hysteresis_threshold #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .hi_thr(hi_thr), .lo_thr(lo_thr),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_out_valid) begin
        outs.push_back(data_out);
        out_cyc.push_back(cyc);
        $display("out k=%0d val=%0d cyc=%0d fd=%0d", outs.size() - 1, data_out, cyc, frame_done);
        if (frame_done) begin
          fd_cnt++;
          fd_idx = outs.size() - 1;
        end
      end else if (frame_done) begin
        fd_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    outs.delete();
    out_cyc.delete();
    fd_cnt = 0;
    fd_idx = -1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N; i++) pix[i] = v;
  endtask

  task automatic set_scn2();
    fill(8'd150);
    pix[5] = 8'd250;
  endtask

  task automatic run_frame(input bit gaps, input bit glitch, input bit flood);
    int t;
    clear_obs();
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        data_in_valid = 1'b0;
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          @(posedge clk); #1;
        end
      end
      if (glitch && i == 8) hi_thr = 8'd0;
      data_in       = pix[i];
      data_in_valid = 1'b1;
      @(posedge clk); #1;
      in_cyc[i]     = cyc;
      data_in_valid = 1'b0;
    end
    if (flood) begin
      data_in       = 8'd250;
      data_in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      data_in_valid = 1'b0;
    end
    t = 0;
    while (outs.size() < N && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    hi_thr = 8'd200;
    $display("frame done: outputs=%0d frame_done=%0d", outs.size(), fd_cnt);
  endtask

  task automatic check_frame(input string name, input logic [15:0] exp_mask, input int exp_ovr);
    int got;
    chk({name, "_count"}, outs.size(), N);
    for (int i = 0; i < N; i++) begin
      got = (i < outs.size()) ? int'(outs[i]) : -1;
      chk($sformatf("%s_px%0d", name, i), got, exp_mask[i] ? 255 : 0);
    end
    chk({name, "_fd_cnt"}, fd_cnt, 1);
    chk({name, "_fd_idx"}, fd_idx, N - 1);
    chk({name, "_overrun"}, int'(overrun), exp_ovr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hi_thr = 8'd200; lo_thr = 8'd100;
    data_in = '0; data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid", int'(data_out_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all weak, no strong seed
    fill(8'd150);
    run_frame(0, 0, 0);
    check_frame("s1", 16'h0000, 0);

    // strong seed at (1,1)
    set_scn2();
    run_frame(0, 0, 0);
    check_frame("s2", 16'h0777, 0);

    // threshold boundaries
    fill(8'd0);
    pix[0] = 8'd200; pix[6] = 8'd99; pix[9] = 8'd200; pix[10] = 8'd201; pix[11] = 8'd100;
    run_frame(0, 0, 0);
    check_frame("s3", 16'h0E00, 0);

    // no wrap between line end and next line start
    fill(8'd0);
    pix[3] = 8'd250; pix[4] = 8'd150; pix[6] = 8'd150;
    run_frame(0, 0, 0);
    check_frame("s4", 16'h0048, 0);

    // bursty input: same map, fixed latency relative to the input stream
    set_scn2();
    run_frame(1, 0, 0);
    check_frame("s5", 16'h0777, 0);
    for (int k = 0; k < N; k++) begin
      int exp_c;
      exp_c = (k <= 10) ? in_cyc[k + 5] + 2 : in_cyc[N - 1] + 2 + (k - 10);
      chk($sformatf("s5_lat%0d", k), (k < out_cyc.size()) ? out_cyc[k] : -1, exp_c);
    end

    // mid-frame threshold change ignored; input during flush dropped and flagged
    set_scn2();
    run_frame(0, 1, 1);
    check_frame("s6", 16'h0777, 1);

    // reset at pixel 7 aborts the frame
    set_scn2();
    clear_obs();
    for (int i = 0; i < 7; i++) begin
      data_in = pix[i]; data_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    data_in = pix[7]; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("s7_data_out", int'(data_out), 0);
    chk("s7_valid", int'(data_out_valid), 0);
    chk("s7_frame_done", int'(frame_done), 0);
    chk("s7_overrun", int'(overrun), 0);
    rst_n = 1'b1; data_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("s7_no_outputs", outs.size(), 0);
    chk("s7_no_fd", fd_cnt, 0);

    // clean frame after the abort
    set_scn2();
    run_frame(0, 0, 0);
    check_frame("s8", 16'h0777, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
